pio_fifo_bank: RTL and testbench

Parametrised TX/RX FIFO bank for the PIO block, replacing the fixed per-machine pair of 4-deep, 32-bit FIFOs with CHANNELS channel pairs of configurable width and depth. Each channel has a host-to-machine TX FIFO and a machine-to-host RX FIFO. Each channel can optionally join its two FIFOs into one double-depth FIFO in either direction. The block also adds level reporting and sticky overflow/underflow error flags. It sits between the PIO host register interface and the state machines.

---
 rtl/pio_fifo_bank.sv | 221 ++++++++++++++++++++++
 tb/tb_pio_fifo_bank.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pio_fifo_bank.sv
// pio_fifo_bank: CHANNELS pairs of TX (host->machine) and RX (machine->host)
// FIFOs for the PIO block, with level reporting and sticky error flags.
//
// Optional feature macro: PIO_FIFO_JOIN_EN
//   defined   -> cfg_wr can join a channel's two FIFOs into one double-depth
//                FIFO (TX or RX); changing the join value flushes the channel.
//   undefined -> every channel is permanently in normal mode, cfg_* ignored.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   host_ch/push/din/pull/dout   host side: push into TX, pop from RX of host_ch
//   m_pull/m_dout                per-channel machine pop of TX (FWFT head)
//   m_push/m_din                 per-channel machine push into RX
//   cfg_wr/ch/join_tx/join_rx    join mode load for one channel
//   tx_/rx_ full/empty/level     per-channel status (registered state)
//   overflow/underflow/err_clr   sticky error flags and per-channel clear

module pio_fifo_chan #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int LW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_wr,
  input  logic             cfg_join_tx,
  input  logic             cfg_join_rx,
  input  logic             tx_push,
  input  logic [WIDTH-1:0] tx_din,
  input  logic             tx_pull,
  input  logic             rx_push,
  input  logic [WIDTH-1:0] rx_din,
  input  logic             rx_pull,
  input  logic             err_clr,
  output logic [WIDTH-1:0] tx_dout,
  output logic [WIDTH-1:0] rx_dout,
  output logic             tx_full,
  output logic             tx_empty,
  output logic             rx_full,
  output logic             rx_empty,
  output logic [LW-1:0]    tx_level,
  output logic [LW-1:0]    rx_level,
  output logic             overflow,
  output logic             underflow
);
  localparam int PW = $clog2(2*DEPTH);
  localparam logic [LW-1:0] CAP1 = LW'(DEPTH);
  localparam logic [LW-1:0] CAP2 = LW'(2*DEPTH);
  localparam logic [PW-1:0] RX_BASE = PW'(DEPTH);

  logic [WIDTH-1:0] mem [2*DEPTH];
  logic [PW-1:0] tx_rp, tx_wp, rx_rp, rx_wp;
  logic jtx, jrx, flush;

`ifdef PIO_FIFO_JOIN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      jtx <= 1'b0;
      jrx <= 1'b0;
    end else if (cfg_wr) begin
      jtx <= cfg_join_tx;
      jrx <= cfg_join_rx;
    end
  end
  assign flush = cfg_wr && ((cfg_join_tx != jtx) || (cfg_join_rx != jrx));
`else
  logic unused_cfg;
  assign jtx = 1'b0;
  assign jrx = 1'b0;
  assign flush = 1'b0;
  assign unused_cfg = cfg_wr ^ cfg_join_tx ^ cfg_join_rx;
`endif

  // Both join bits set falls back to normal mode.
  logic tx_jn, rx_jn;
  logic [LW-1:0] tx_cap, rx_cap;
  assign tx_jn  = jtx & ~jrx;
  assign rx_jn  = jrx & ~jtx;
  // A disabled direction has capacity 0, so it reads as both full and empty.
  assign tx_cap = tx_jn ? CAP2 : (rx_jn ? '0 : CAP1);
  assign rx_cap = rx_jn ? CAP2 : (tx_jn ? '0 : CAP1);

  assign tx_full  = (tx_level == tx_cap);
  assign tx_empty = (tx_level == '0);
  assign rx_full  = (rx_level == rx_cap);
  assign rx_empty = (rx_level == '0);

  // A full FIFO still accepts a push when a pull frees a slot the same cycle.
  logic tx_pull_ok, tx_push_ok, rx_pull_ok, rx_push_ok;
  assign tx_pull_ok = tx_pull && !tx_empty;
  assign tx_push_ok = tx_push && (!tx_full || tx_pull_ok);
  assign rx_pull_ok = rx_pull && !rx_empty;
  assign rx_push_ok = rx_push && (!rx_full || rx_pull_ok);

  logic ovf_set, unf_set;
  assign ovf_set = !flush && ((tx_push && !tx_push_ok) || (rx_push && !rx_push_ok));
  assign unf_set = !flush && ((tx_pull && !tx_pull_ok) || (rx_pull && !rx_pull_ok));

  // RX lives in the upper half of storage unless it owns the whole array.
  logic [PW-1:0] rx_base;
  assign rx_base = rx_jn ? '0 : RX_BASE;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p, input logic [LW-1:0] cap);
    nxt = (({1'b0, p} + LW'(1)) == cap) ? '0 : p + PW'(1);
  endfunction

  assign tx_dout = tx_empty ? '0 : mem[tx_rp];
  assign rx_dout = rx_empty ? '0 : mem[rx_rp + rx_base];

  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      if (tx_push_ok) mem[tx_wp] <= tx_din;
      if (rx_push_ok) mem[rx_wp + rx_base] <= rx_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      tx_rp <= '0; tx_wp <= '0; tx_level <= '0;
      rx_rp <= '0; rx_wp <= '0; rx_level <= '0;
    end else begin
      if (tx_push_ok) tx_wp <= nxt(tx_wp, tx_cap);
      if (tx_pull_ok) tx_rp <= nxt(tx_rp, tx_cap);
      if (rx_push_ok) rx_wp <= nxt(rx_wp, rx_cap);
      if (rx_pull_ok) rx_rp <= nxt(rx_rp, rx_cap);
      tx_level <= tx_level + LW'(tx_push_ok) - LW'(tx_pull_ok);
      rx_level <= rx_level + LW'(rx_push_ok) - LW'(rx_pull_ok);
    end
  end

  // Clear wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (err_clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set) overflow  <= 1'b1;
      if (unf_set) underflow <= 1'b1;
    end
  end
endmodule

module pio_fifo_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LW = $clog2(2*DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CW-1:0]             host_ch,
  input  logic                      host_push,
  input  logic [WIDTH-1:0]          host_din,
  input  logic                      host_pull,
  output logic [WIDTH-1:0]          host_dout,
  input  logic [CHANNELS-1:0]       m_pull,
  output logic [CHANNELS*WIDTH-1:0] m_dout,
  input  logic [CHANNELS-1:0]       m_push,
  input  logic [CHANNELS*WIDTH-1:0] m_din,
  input  logic                      cfg_wr,
  input  logic [CW-1:0]             cfg_ch,
  input  logic                      cfg_join_tx,
  input  logic                      cfg_join_rx,
  output logic [CHANNELS-1:0]       tx_full,
  output logic [CHANNELS-1:0]       tx_empty,
  output logic [CHANNELS-1:0]       rx_full,
  output logic [CHANNELS-1:0]       rx_empty,
  output logic [CHANNELS*LW-1:0]    tx_level,
  output logic [CHANNELS*LW-1:0]    rx_level,
  output logic [CHANNELS-1:0]       overflow,
  output logic [CHANNELS-1:0]       underflow,
  input  logic [CHANNELS-1:0]       err_clr
);
  logic [CHANNELS-1:0][WIDTH-1:0] tx_dout_a, rx_dout_a, m_din_a;
  logic [CHANNELS-1:0][LW-1:0]    tx_lvl_a, rx_lvl_a;

  assign m_din_a  = m_din;
  assign m_dout   = tx_dout_a;
  assign tx_level = tx_lvl_a;
  assign rx_level = rx_lvl_a;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic hsel;
    assign hsel = (host_ch == CW'(g));
    pio_fifo_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LW(LW)) u_ch (
      .clk         (clk),
      .reset       (reset),
      .cfg_wr      (cfg_wr && (cfg_ch == CW'(g))),
      .cfg_join_tx (cfg_join_tx),
      .cfg_join_rx (cfg_join_rx),
      .tx_push     (host_push && hsel),
      .tx_din      (host_din),
      .tx_pull     (m_pull[g]),
      .rx_push     (m_push[g]),
      .rx_din      (m_din_a[g]),
      .rx_pull     (host_pull && hsel),
      .err_clr     (err_clr[g]),
      .tx_dout     (tx_dout_a[g]),
      .rx_dout     (rx_dout_a[g]),
      .tx_full     (tx_full[g]),
      .tx_empty    (tx_empty[g]),
      .rx_full     (rx_full[g]),
      .rx_empty    (rx_empty[g]),
      .tx_level    (tx_lvl_a[g]),
      .rx_level    (rx_lvl_a[g]),
      .overflow    (overflow[g]),
      .underflow   (underflow[g])
    );
  end

  // Out-of-range host_ch reads as an empty FIFO.
  always_comb begin
    host_dout = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (host_ch == CW'(c)) host_dout = rx_dout_a[c];
  end
endmodule

// File: tb/tb_pio_fifo_bank.sv
module tb_pio_fifo_bank;
  localparam int CH = 4, W = 32, LW = 4;

  logic clk = 0, reset = 1;
  logic [1:0] host_ch = 0, cfg_ch = 0;
  logic host_push = 0, host_pull = 0, cfg_wr = 0, cfg_join_tx = 0, cfg_join_rx = 0;
  logic [W-1:0] host_din = 0, host_dout;
  logic [CH-1:0] m_pull = 0, m_push = 0, err_clr = 0;
  logic [CH*W-1:0] m_dout, m_din = 0;
  logic [CH-1:0] tx_full, tx_empty, rx_full, rx_empty, overflow, underflow;
  logic [CH*LW-1:0] tx_level, rx_level;
  int checks = 0, errors = 0;

  pio_fifo_bank #(.CHANNELS(CH), .WIDTH(W), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .host_ch(host_ch), .host_push(host_push),
    .host_din(host_din), .host_pull(host_pull), .host_dout(host_dout),
    .m_pull(m_pull), .m_dout(m_dout), .m_push(m_push), .m_din(m_din),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_join_tx(cfg_join_tx), .cfg_join_rx(cfg_join_rx),
    .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
    .tx_level(tx_level), .rx_level(rx_level), .overflow(overflow), .underflow(underflow),
    .err_clr(err_clr));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic hpush(input logic [1:0] ch, input logic [W-1:0] d);
    host_ch = ch; host_din = d; host_push = 1; tick; host_push = 0;
  endtask

  task automatic hpull(input logic [1:0] ch);
    host_ch = ch; host_pull = 1; tick; host_pull = 0;
  endtask

  task automatic mpull(input int c);
    m_pull[c] = 1; tick; m_pull = 0;
  endtask

  task automatic mpush(input int c, input logic [W-1:0] d);
    m_din[c*W +: W] = d; m_push[c] = 1; tick; m_push = 0;
  endtask

  task automatic clr(input logic [CH-1:0] m);
    err_clr = m; tick; err_clr = 0;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic jt, input logic jr);
    cfg_ch = ch; cfg_join_tx = jt; cfg_join_rx = jr; cfg_wr = 1; tick; cfg_wr = 0;
  endtask

  task automatic test_reset;
    checks++; if (tx_empty !== 4'hF) begin errors++; $display("FAIL rst_tx_empty got %h want f", tx_empty); end
    checks++; if (rx_empty !== 4'hF) begin errors++; $display("FAIL rst_rx_empty got %h want f", rx_empty); end
    checks++; if ({tx_full, rx_full} !== 8'h00) begin errors++; $display("FAIL rst_full got %h want 00", {tx_full, rx_full}); end
    checks++; if (m_dout !== '0) begin errors++; $display("FAIL rst_m_dout got %h want 0", m_dout); end
    checks++; if (host_dout !== '0) begin errors++; $display("FAIL rst_host_dout got %h want 0", host_dout); end
    checks++; if ({overflow, underflow} !== 8'h00) begin errors++; $display("FAIL rst_flags got %h want 00", {overflow, underflow}); end
  endtask

  task automatic test_fill;
    logic [W-1:0] exp [4];
    exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33; exp[3] = 32'h44;
    for (int i = 0; i < 4; i++) hpush(0, exp[i]);
    checks++; if (tx_full[0] !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", tx_full[0]); end
    checks++; if (tx_level[3:0] !== 4'd4) begin errors++; $display("FAIL fill_level got %0d want 4", tx_level[3:0]); end
    hpush(0, 32'h55);
    checks++; if (overflow[0] !== 1'b1) begin errors++; $display("FAIL fill_ovf got %b want 1", overflow[0]); end
    checks++; if (tx_level[3:0] !== 4'd4) begin errors++; $display("FAIL fill_ovf_level got %0d want 4", tx_level[3:0]); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_dout[31:0] !== exp[i]) begin errors++; $display("FAIL fill_pop%0d got %h want %h", i, m_dout[31:0], exp[i]); end
      mpull(0);
    end
    checks++; if (tx_empty[0] !== 1'b1) begin errors++; $display("FAIL fill_empty got %b want 1", tx_empty[0]); end
    checks++; if (m_dout[31:0] !== 32'h0) begin errors++; $display("FAIL fill_dout0 got %h want 0", m_dout[31:0]); end
    clr(4'h1);
    checks++; if (overflow[0] !== 1'b0) begin errors++; $display("FAIL fill_clr got %b want 0", overflow[0]); end
  endtask

  task automatic test_simul;
    hpush(0, 32'hA1); hpush(0, 32'hA2);
    host_ch = 0; host_din = 32'hA3; host_push = 1; m_pull[0] = 1; tick; host_push = 0; m_pull = 0;
    checks++; if (tx_level[3:0] !== 4'd2) begin errors++; $display("FAIL sim_level got %0d want 2", tx_level[3:0]); end
    checks++; if (m_dout[31:0] !== 32'hA2) begin errors++; $display("FAIL sim_head got %h want a2", m_dout[31:0]); end
    mpull(0);
    checks++; if (m_dout[31:0] !== 32'hA3) begin errors++; $display("FAIL sim_order got %h want a3", m_dout[31:0]); end
    mpull(0);
    // empty: pull + push -> underflow, push lands
    host_din = 32'hB1; host_push = 1; m_pull[0] = 1; tick; host_push = 0; m_pull = 0;
    checks++; if (underflow[0] !== 1'b1) begin errors++; $display("FAIL sim_unf got %b want 1", underflow[0]); end
    checks++; if (tx_level[3:0] !== 4'd1) begin errors++; $display("FAIL sim_unf_level got %0d want 1", tx_level[3:0]); end
    checks++; if (m_dout[31:0] !== 32'hB1) begin errors++; $display("FAIL sim_unf_head got %h want b1", m_dout[31:0]); end
    clr(4'h1); mpull(0);
    // full: push + pull both succeed, no overflow
    for (int i = 1; i <= 4; i++) hpush(0, 32'hC0 + i);
    host_din = 32'hC5; host_push = 1; m_pull[0] = 1; tick; host_push = 0; m_pull = 0;
    checks++; if (overflow[0] !== 1'b0) begin errors++; $display("FAIL sim_full_ovf got %b want 0", overflow[0]); end
    checks++; if (tx_level[3:0] !== 4'd4) begin errors++; $display("FAIL sim_full_level got %0d want 4", tx_level[3:0]); end
    for (int i = 2; i <= 5; i++) begin
      checks++; if (m_dout[31:0] !== 32'hC0 + i) begin errors++; $display("FAIL sim_full_pop got %h want %h", m_dout[31:0], 32'hC0 + i); end
      mpull(0);
    end
    // clear beats a same-cycle underflow
    m_pull[0] = 1; err_clr[0] = 1; tick; m_pull = 0; err_clr = 0;
    checks++; if (underflow[0] !== 1'b0) begin errors++; $display("FAIL sim_clr_prio got %b want 0", underflow[0]); end
  endtask

  task automatic test_isolation;
    host_ch = 3; host_din = 32'hE0; host_push = 1; m_din[31:0] = 32'hD0; m_push[0] = 1; tick;
    host_din = 32'hE1; m_din[31:0] = 32'hD1; tick; host_push = 0; m_push = 0;
    host_ch = 0; #1;
    checks++; if (host_dout !== 32'hD0) begin errors++; $display("FAIL iso_host_dout got %h want d0", host_dout); end
    checks++; if (m_dout[3*W +: W] !== 32'hE0) begin errors++; $display("FAIL iso_m3 got %h want e0", m_dout[3*W +: W]); end
    checks++; if (m_dout[31:0] !== 32'h0) begin errors++; $display("FAIL iso_m0 got %h want 0", m_dout[31:0]); end
    checks++; if ({rx_level[3:0], tx_level[15:12], tx_level[3:0]} !== 12'h220) begin errors++; $display("FAIL iso_levels got %h want 220", {rx_level[3:0], tx_level[15:12], tx_level[3:0]}); end
    checks++; if (rx_empty[3] !== 1'b1) begin errors++; $display("FAIL iso_rx3 got %b want 1", rx_empty[3]); end
    hpull(0);
    checks++; if (host_dout !== 32'hD1) begin errors++; $display("FAIL iso_pop got %h want d1", host_dout); end
    hpull(2);
    checks++; if (underflow !== 4'h4) begin errors++; $display("FAIL iso_unf2 got %h want 4", underflow); end
    reset = 1; tick; reset = 0; #1;
    checks++; if ({tx_empty, rx_empty} !== 8'hFF) begin errors++; $display("FAIL mrst_empty got %h want ff", {tx_empty, rx_empty}); end
    checks++; if ({tx_level, rx_level} !== '0) begin errors++; $display("FAIL mrst_levels got %h want 0", {tx_level, rx_level}); end
    checks++; if ({overflow, underflow} !== 8'h00) begin errors++; $display("FAIL mrst_flags got %h want 00", {overflow, underflow}); end
    checks++; if (m_dout !== '0) begin errors++; $display("FAIL mrst_m_dout got %h want 0", m_dout); end
  endtask

`ifdef PIO_FIFO_JOIN_EN
  task automatic test_join_tx;
    cfg(2, 1, 0);
    for (int i = 0; i < 8; i++) hpush(2, 32'h200 + i);
    checks++; if (tx_level[11:8] !== 4'd8) begin errors++; $display("FAIL jtx_level got %0d want 8", tx_level[11:8]); end
    checks++; if (overflow[2] !== 1'b0) begin errors++; $display("FAIL jtx_no_ovf got %b want 0", overflow[2]); end
    hpush(2, 32'h208);
    checks++; if (overflow[2] !== 1'b1) begin errors++; $display("FAIL jtx_ovf got %b want 1", overflow[2]); end
    checks++; if ({rx_empty[2], rx_full[2], rx_level[11:8]} !== 6'b110000) begin errors++; $display("FAIL jtx_rx_dis got %b want 110000", {rx_empty[2], rx_full[2], rx_level[11:8]}); end
    clr(4'h4);
    mpush(2, 32'hDEAD);
    checks++; if (overflow[2] !== 1'b1) begin errors++; $display("FAIL jtx_rx_push got %b want 1", overflow[2]); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (m_dout[2*W +: W] !== 32'h200 + i) begin errors++; $display("FAIL jtx_pop got %h want %h", m_dout[2*W +: W], 32'h200 + i); end
      mpull(2);
    end
  endtask

  task automatic test_join_flush;
    for (int i = 0; i < 3; i++) mpush(1, 32'h100 + i);
    hpush(1, 32'h1F0);
    checks++; if ({rx_level[7:4], tx_level[7:4]} !== 8'h31) begin errors++; $display("FAIL jfl_pre got %h want 31", {rx_level[7:4], tx_level[7:4]}); end
    cfg(1, 0, 1);
    checks++; if ({rx_level[7:4], tx_level[7:4]} !== 8'h00) begin errors++; $display("FAIL jfl_flush got %h want 00", {rx_level[7:4], tx_level[7:4]}); end
    for (int i = 0; i < 3; i++) mpush(1, 32'h110 + i);
    cfg(1, 0, 1);
    host_ch = 1; #1;
    checks++; if (rx_level[7:4] !== 4'd3) begin errors++; $display("FAIL jfl_keep got %0d want 3", rx_level[7:4]); end
    checks++; if (host_dout !== 32'h110) begin errors++; $display("FAIL jfl_head got %h want 110", host_dout); end
  endtask
`else
  task automatic test_no_join;
    cfg(0, 1, 0);
    for (int i = 0; i < 4; i++) hpush(0, 32'h300 + i);
    checks++; if (tx_level[3:0] !== 4'd4) begin errors++; $display("FAIL nj_level got %0d want 4", tx_level[3:0]); end
    checks++; if (overflow[0] !== 1'b0) begin errors++; $display("FAIL nj_pre_ovf got %b want 0", overflow[0]); end
    hpush(0, 32'h304);
    checks++; if (overflow[0] !== 1'b1) begin errors++; $display("FAIL nj_ovf got %b want 1", overflow[0]); end
    checks++; if (rx_full[0] !== 1'b0) begin errors++; $display("FAIL nj_rx_full got %b want 0", rx_full[0]); end
  endtask
`endif

  initial begin
    tick; tick; reset = 0; #1;
    test_reset;
    test_fill;
    test_simul;
    test_isolation;
`ifdef PIO_FIFO_JOIN_EN
    test_join_tx;
    test_join_flush;
`else
    test_no_join;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
